// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display path: hex segment patterns
// (active-high, bit 6 = A .. bit 0 = G), the all-off pin value and blink counter width.
package seven_seg_pkg;

   localparam int unsigned BLINK_W = 24;
   localparam logic [6:0]  SEG_OFF = 7'b1111111;

   localparam logic [6:0] SEG_0 = 7'h7E;
   localparam logic [6:0] SEG_1 = 7'h30;
   localparam logic [6:0] SEG_2 = 7'h6D;
   localparam logic [6:0] SEG_3 = 7'h79;
   localparam logic [6:0] SEG_4 = 7'h33;
   localparam logic [6:0] SEG_5 = 7'h5B;
   localparam logic [6:0] SEG_6 = 7'h5F;
   localparam logic [6:0] SEG_7 = 7'h70;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h7B;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h1F;
   localparam logic [6:0] SEG_C = 7'h4E;
   localparam logic [6:0] SEG_D = 7'h3D;
   localparam logic [6:0] SEG_E = 7'h4F;
   localparam logic [6:0] SEG_F = 7'h47;

   function automatic logic [6:0] hex_decode(input logic [3:0] value);
      logic [6:0] pattern;
      case (value)
         4'h0:    pattern = SEG_0;
         4'h1:    pattern = SEG_1;
         4'h2:    pattern = SEG_2;
         4'h3:    pattern = SEG_3;
         4'h4:    pattern = SEG_4;
         4'h5:    pattern = SEG_5;
         4'h6:    pattern = SEG_6;
         4'h7:    pattern = SEG_7;
         4'h8:    pattern = SEG_8;
         4'h9:    pattern = SEG_9;
         4'hA:    pattern = SEG_A;
         4'hB:    pattern = SEG_B;
         4'hC:    pattern = SEG_C;
         4'hD:    pattern = SEG_D;
         4'hE:    pattern = SEG_E;
         default: pattern = SEG_F;
      endcase
      return pattern;
   endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble to active-high segment pattern decoder.
module seg_hex_decoder
   import seven_seg_pkg::*;
(
   input  logic [3:0] value,
   output logic [6:0] seg_c
);

   always_comb begin
      seg_c = hex_decode(value);
   end

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexed N-digit common-anode seven-segment controller with shadowed
// digit data, per-slot dead time, per-digit blink and blank.
module seven_segment_mux
   import seven_seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned DEAD_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   input  logic [BLINK_W-1:0]      blink_rate,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an
);

   localparam int unsigned REF_W = $clog2(REFRESH_DIV);
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_DIV - 1);
   localparam logic [REF_W-1:0] DEAD_LAST = REF_W'(DEAD_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   logic [REF_W-1:0]        ref_cnt;
   logic [IDX_W-1:0]        idx;
   logic [BLINK_W-1:0]      blink_cnt;
   logic                    blink_phase;

   logic [4*NUM_DIGITS-1:0] digits_sh;
   logic [NUM_DIGITS-1:0]   dp_sh;
   logic [NUM_DIGITS-1:0]   blink_sh;
   logic [NUM_DIGITS-1:0]   blank_sh;

   logic [3:0]              digit_c;
   logic [6:0]              seg_hi_c;
   logic                    visible_c;

   // Slot timer and digit index; idx advances as the slot timer wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         ref_cnt <= '0;
         idx     <= '0;
      end else if (ref_cnt == REF_LAST) begin
         ref_cnt <= '0;
         idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
         ref_cnt <= ref_cnt + REF_W'(1);
      end
   end

   // Blink half-period timer; a rate of zero parks the phase in the visible state.
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (blink_rate == '0) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (blink_cnt >= blink_rate - BLINK_W'(1)) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + BLINK_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digits_sh <= '0;
         dp_sh     <= '0;
         blink_sh  <= '0;
         blank_sh  <= '0;
      end else if (load) begin
         digits_sh <= digits_in;
         dp_sh     <= dp_in;
         blink_sh  <= blink_mask;
         blank_sh  <= blank_mask;
      end
   end

   always_comb begin
      digit_c   = digits_sh[{idx, 2'b00} +: 4];
      visible_c = (ref_cnt >= DEAD_LAST) && !blank_sh[idx] &&
                  !(blink_sh[idx] && !blink_phase);
   end

   seg_hex_decoder u_dec (
      .value (digit_c),
      .seg_c (seg_hi_c)
   );

   // Pin register: everything shown comes from state sampled before this edge,
   // so digit data and anode always move together.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg <= SEG_OFF;
         dp  <= 1'b1;
         an  <= '1;
      end else if (visible_c) begin
         seg <= ~seg_hi_c;
         dp  <= ~dp_sh[idx];
         an  <= ~(NUM_DIGITS'(1) << idx);
      end else begin
         seg <= SEG_OFF;
         dp  <= 1'b1;
         an  <= '1;
      end
   end

endmodule

// File: tb/tb_seven_segment_mux.sv
// Randomised self-checking bench for seven_segment_mux against a time-based display model.
module tb_seven_segment_mux;

   localparam int ND = 4;
   localparam int RD = 8;
   localparam int DC = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            load;
   logic [4*ND-1:0] digits_in;
   logic [ND-1:0]   dp_in;
   logic [ND-1:0]   blink_mask;
   logic [ND-1:0]   blank_mask;
   logic [23:0]     blink_rate;
   logic [6:0]      seg;
   logic            dp;
   logic [ND-1:0]   an;

   int vectors = 0;
   int miscompares = 0;

   seven_segment_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .blink_mask (blink_mask),
      .blank_mask (blank_mask),
      .blink_rate (blink_rate),
      .seg        (seg),
      .dp         (dp),
      .an         (an)
   );

   always #5 clk = ~clk;

   // Model: pin values follow from edges elapsed since reset and since the blink
   // rate became non-zero; the bench only changes the rate by passing through zero.
   logic [6:0] hex_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
   int          e = 0;
   int          m = 0;
   int          prev_rate = 0;
   logic [15:0] sh_dig;
   logic [3:0]  sh_dp, sh_blink, sh_blank;
   logic        model_valid = 1'b0;
   logic [6:0]  exp_seg;
   logic        exp_dp;
   logic [3:0]  exp_an;

   always @(posedge clk) begin
      int  slot_pos, slot_idx;
      logic phase, vis;
      if (rst) begin
         exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF;
         e = 0; m = 0; prev_rate = 0;
         sh_dig = '0; sh_dp = '0; sh_blink = '0; sh_blank = '0;
         model_valid = 1'b1;
      end else begin
         slot_pos = e % RD;
         slot_idx = (e / RD) % ND;
         phase = (prev_rate == 0) ? 1'b1 : (((m / prev_rate) % 2) == 0);
         vis = (slot_pos >= DC) && !sh_blank[slot_idx] && !(sh_blink[slot_idx] && !phase);
         if (vis) begin
            exp_seg = ~hex_tab[(sh_dig >> (4 * slot_idx)) & 16'hF];
            exp_dp  = ~sh_dp[slot_idx];
            exp_an  = ~(4'd1 << slot_idx);
         end else begin
            exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF;
         end
         if (blink_rate == 0) m = 0; else m = m + 1;
         prev_rate = int'(blink_rate);
         if (load) begin
            sh_dig = digits_in; sh_dp = dp_in; sh_blink = blink_mask; sh_blank = blank_mask;
         end
         e = e + 1;
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         vectors++;
         if ({seg, dp, an} !== {exp_seg, exp_dp, exp_an}) begin
            miscompares++;
            $display("FAIL model t=%0t seg=%h dp=%b an=%h expected seg=%h dp=%b an=%h",
                     $time, seg, dp, an, exp_seg, exp_dp, exp_an);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s got=%h expected=%h", name, got, want);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reset, then load at the first edge after release; returns just after edge 1.
   task automatic reset_and_load(input logic [15:0] d, input logic [3:0] p);
      rst = 1'b1; load = 1'b0;
      step(1);
      rst = 1'b0; load = 1'b1; digits_in = d; dp_in = p;
      blink_mask = '0; blank_mask = '0; blink_rate = '0;
      step(1);
      load = 1'b0;
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0;
      blink_mask = '0; blank_mask = '0; blink_rate = '0;
      step(2);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_dp",  32'(dp),  32'h1);
      check("rst_an",  32'(an),  32'hF);

      reset_and_load(16'h1234, 4'b0100);
      step(1);  check("dead_an_e2", 32'(an), 32'hF);
      step(1);  check("first_an_e3", 32'(an), 32'hE);
      check("d0_seg", 32'(seg), 32'(~7'h33 & 7'h7F));
      step(5);  check("last_an_e8", 32'(an), 32'hE);
      step(1);  check("dead_an_e9", 32'(an), 32'hF);
      step(4);  check("d1_an", 32'(an), 32'hD);
      check("d1_seg", 32'(seg), 32'(~7'h79 & 7'h7F));
      step(8);  check("d2_an", 32'(an), 32'hB);
      check("d2_seg", 32'(seg), 32'(~7'h6D & 7'h7F));
      check("d2_dp",  32'(dp),  32'h0);
      step(8);  check("d3_an", 32'(an), 32'h7);
      check("d3_seg", 32'(seg), 32'(~7'h30 & 7'h7F));
      check("d3_dp",  32'(dp),  32'h1);

      reset_and_load(16'h000A, 4'b0000);
      step(4);  check("dec_A", 32'(seg), 32'(~7'h77 & 7'h7F));
      reset_and_load(16'h000F, 4'b0000);
      step(4);  check("dec_F", 32'(seg), 32'(~7'h47 & 7'h7F));

      // Decode sweep on digit 0, checked by the model every cycle.
      for (int v = 0; v < 16; v++) begin
         reset_and_load(16'(v), 4'b0001);
         step(6);
      end

      // Directed blink and blank windows, then random traffic.
      load = 1'b1; blink_mask = 4'b0001; blank_mask = 4'b0000; digits_in = 16'h5678;
      blink_rate = 24'd5;
      step(1); load = 1'b0;
      step(80);
      blink_rate = 24'd0;
      step(40);
      load = 1'b1; blink_mask = 4'b0000; blank_mask = 4'b1010;
      step(1); load = 1'b0;
      step(64);

      for (int i = 0; i < 4000; i++) begin
         rst  = ($urandom % 600) == 0;
         load = ($urandom % 10) == 0;
         digits_in  = 16'($urandom);
         dp_in      = 4'($urandom);
         blink_mask = 4'($urandom);
         blank_mask = 4'($urandom) & 4'($urandom) & 4'($urandom);
         if (($urandom % 150) == 0) begin
            if (blink_rate != 0) blink_rate = 24'd0;
            else blink_rate = 24'($urandom_range(1, 9));
         end
         step(1);
      end
      rst = 1'b0; load = 1'b0;
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
